prod_accum: RTL and testbench
=============================

# prod_accum

Sequential accumulate stage sitting directly downstream of the 4-bit array multiplier. It consumes the multiplier's 8-bit combinational product one term per accepted cycle. It sums a programmed number of terms (1–15) into a registered accumulator and reports completion, so the lab datapath can compute dot products of 4-bit vectors.

## Interface
Parameters:
- ACC_W, 12, accumulator width. 12 covers the worst case of 15 × 225 = 3375 without wrap.
- LEN_W, 4, width of the term-count field.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse that begins a new accumulation.
- len  in  LEN_W  number of terms; sampled only when start=1.
- in_valid  in  1  prod is a valid term this cycle.
- prod  in  8  unsigned product from the multiplier.
- in_ready  out  1  stage accepts terms; equals busy.
- busy  out  1  state is ACCUM.
- done  out  1  state is DONE; acc holds the final sum.
- acc  out  ACC_W  accumulator, unsigned.
- ovf  out  1  sticky flag; carry out of ACC_W occurred during the current run.

## Operation
States:
- IDLE: reset state. No accumulation is performed.
- ACCUM: terms are being summed.
- DONE: final result is held.

Transitions:
- start=1 in any state:
  - acc←0, ovf←0, cnt←0, len_q←len.
  - Next state is ACCUM, or DONE if len=0.
  - start overrides a run in progress; the partial sum is discarded.
- ACCUM with in_valid=1:
  - acc←(acc+prod) mod 2^ACC_W, with prod zero-extended.
  - ovf←ovf | carry-out.
  - cnt←cnt+1.
  - If cnt+1 == len_q, next state is DONE; otherwise stay in ACCUM.
- ACCUM with in_valid=0: everything holds. Gaps are unlimited.
- IDLE or DONE with in_valid=1: ignored. acc, ovf and the state are unchanged.
- DONE with start=0: holds indefinitely, with done=1 and acc/ovf frozen.
- rst=1: takes priority over start. Next state is IDLE and all registers clear, including mid-run.

Width rules:
- cnt and len_q are LEN_W bits.
- len is unsigned, range 0..2^LEN_W−1.
- ovf never self-clears; only start or rst clear it.

## Timing
- Reset values: acc=0, ovf=0, done=0, busy=0, in_ready=0, cnt=0, state IDLE.
- All outputs are registered or decoded directly from the state register. There is no combinational path from inputs to outputs.
- Start: the start edge puts the block in ACCUM, so busy=1 in the following cycle.
  - With len=0, done=1 in the following cycle and acc=0.
- Term acceptance: a term is accepted on a rising edge where state=ACCUM and in_valid=1. acc reflects it in the next cycle.
- Run length: with in_valid held high, the block spends len cycles in ACCUM after the start cycle.
  - done rises on the edge that accepts the last term, in the same cycle acc first shows the final sum.
- Back-to-back runs: start asserted while done=1 gives busy=1 in the next cycle. No dead cycle is required.
- Producer side: upstream must drive prod only when in_ready=1. Terms offered while in_ready=0 are dropped by design.

## Test plan
- Full run:
  - Stimulus: rst, then start with len=6. Feed products 117 (13×9), 117 (9×13), 42 (6×7), 50 (5×10), 21 (7×3), 98 (14×7) on consecutive cycles.
  - Required: acc partials 117, 234, 276, 326, 347, 445. done=1 in the cycle acc=445 (0x1BD) first appears, ovf=0, busy=0 thereafter.
- Gapped valid:
  - Stimulus: same six terms with in_valid deasserted for 2 cycles between each.
  - Required: acc=445 and done asserted exactly after the 6th accepted term. acc holds during the gaps.
- Zero length and ignored input:
  - Stimulus: start with len=0, then in_valid=1 with prod=200 while done=1.
  - Required: done=1 and acc=0 in the cycle after start. acc stays 0 and done stays 1.
- Overflow:
  - Stimulus: instance with ACC_W=8; start with len=3 and terms 117, 117, 42.
  - Required: acc=234, then 20 (276 mod 256). ovf=1 from the third term's cycle onward. The next start clears ovf to 0.
- Restart and reset mid-run:
  - Stimulus: start with len=6, accept 117 and 117, pulse start with len=2, then feed 42 and 50.
    - Required: acc=92 and done=1.
  - Stimulus: start again, accept one term, then assert rst.
    - Required: acc=0, busy=0, done=0, ovf=0 on the next cycle.
- Back-to-back:
  - Stimulus: start asserted in the cycle done=1.
  - Required: busy=1 in the next cycle and acc=0 before the first new term.

Source files
------------

// File: rtl/prod_accum.sv
// Accumulate stage behind the 4-bit array multiplier: sums a programmed number
// of 8-bit products into a registered accumulator and flags completion.
module prod_accum #(
    parameter int ACC_W = 12,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       prod,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Zero-extended add of one product; MSB of the result is the carry out.
    function automatic logic [ACC_W:0] add_term(input logic [ACC_W-1:0] a,
                                                input logic [7:0]       p);
        add_term = {1'b0, a} + (ACC_W+1)'(p);
    endfunction

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ACC_W:0]     sum_s;
    logic [LEN_W-1:0]   cnt_inc_s;

    // Next-state, accumulate and status decode.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sum_s     = add_term(acc_q, prod);
        cnt_inc_s = cnt_q + LEN_W'(1);

        if (start) begin
            // A new start always wins, discarding any partial sum.
            acc_d = {ACC_W{1'b0}};
            ovf_d = 1'b0;
            cnt_d = {LEN_W{1'b0}};
            len_d = len;
            if (len == {LEN_W{1'b0}}) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_ACCUM;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum_s[ACC_W-1:0];
                        ovf_d = ovf_q | sum_s[ACC_W];
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == len_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_ACCUM);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            ovf_q   <= 1'b0;
            cnt_q   <= {LEN_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign acc      = acc_q;
    assign ovf      = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = busy_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: directed test-plan scenarios plus random traffic, with
// a 12-bit and an 8-bit instance checked every cycle against a sum-level model.
module tb_prod_accum;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] prod;

    logic        rdy12, busy12, done12, ovf12;
    logic [11:0] acc12;
    logic        rdy8, busy8, done8, ovf8;
    logic [7:0]  acc8;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run started, terms still owed, running exact total.
    bit m_started;
    int m_left;
    int m_total;

    prod_accum #(.ACC_W(12), .LEN_W(4)) dut12 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .prod(prod), .in_ready(rdy12),
        .busy(busy12), .done(done12), .acc(acc12), .ovf(ovf12)
    );

    prod_accum #(.ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .prod(prod), .in_ready(rdy8),
        .busy(busy8), .done(done8), .acc(acc8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input int ln,
                              input bit v, input int p);
        if (r) begin
            m_started = 1'b0; m_left = 0; m_total = 0;
        end else if (st) begin
            m_started = 1'b1; m_left = ln; m_total = 0;
        end else if (m_started && m_left > 0 && v) begin
            m_total += p;
            m_left--;
        end
    endtask

    task automatic check_model();
        bit e_busy, e_done;
        e_busy = m_started && (m_left > 0);
        e_done = m_started && (m_left == 0);
        check_eq("acc12",   acc12,  m_total % 4096);
        check_eq("ovf12",   ovf12,  int'(m_total >= 4096));
        check_eq("busy12",  busy12, int'(e_busy));
        check_eq("rdy12",   rdy12,  int'(e_busy));
        check_eq("done12",  done12, int'(e_done));
        check_eq("acc8",    acc8,   m_total % 256);
        check_eq("ovf8",    ovf8,   int'(m_total >= 256));
        check_eq("busy8",   busy8,  int'(e_busy));
        check_eq("done8",   done8,  int'(e_done));
    endtask

    // One clock: drive inputs, advance model on the edge, check 1 time unit after.
    task automatic cyc(input bit r, input bit st, input int ln, input bit v, input int p);
        rst = r; start = st; len = 4'(ln); in_valid = v; prod = 8'(p);
        @(posedge clk);
        model_step(r, st, ln, v, p);
        #1;
        check_model();
    endtask

    int terms[6]    = '{117, 117, 42, 50, 21, 98};
    int partials[6] = '{117, 234, 276, 326, 347, 445};

    initial begin
        m_started = 1'b0; m_left = 0; m_total = 0;
        rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0; prod = 8'd0;

        // Reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check_eq("rst_acc", acc12, 0);
        check_eq("rst_busy", busy12, 0);
        check_eq("rst_done", done12, 0);
        cyc(0, 0, 0, 1, 99);
        check_eq("idle_ignore_acc", acc12, 0);

        // Full run
        cyc(0, 1, 6, 0, 0);
        check_eq("full_busy_after_start", busy12, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, terms[i]);
            check_eq("full_partial", acc12, partials[i]);
            check_eq("full_done", done12, int'(i == 5));
        end
        check_eq("full_ovf", ovf12, 0);
        cyc(0, 0, 0, 1, 77);
        check_eq("full_hold_acc", acc12, 445);
        check_eq("full_busy_after", busy12, 0);

        // Gapped valid
        cyc(0, 1, 6, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, terms[i]);
            check_eq("gap_done", done12, int'(i == 5));
            if (i < 5) begin
                for (int g = 0; g < 2; g++) begin
                    cyc(0, 0, 0, 0, 200);
                    check_eq("gap_hold", acc12, partials[i]);
                end
            end
        end
        check_eq("gap_acc", acc12, 445);

        // Zero length and ignored input
        cyc(0, 1, 0, 0, 0);
        check_eq("zero_done", done12, 1);
        check_eq("zero_acc", acc12, 0);
        cyc(0, 0, 0, 1, 200);
        check_eq("zero_ign_acc", acc12, 0);
        check_eq("zero_ign_done", done12, 1);

        // Overflow on the 8-bit instance
        cyc(0, 1, 3, 0, 0);
        cyc(0, 0, 0, 1, 117);
        cyc(0, 0, 0, 1, 117);
        check_eq("ovf8_p2", acc8, 234);
        check_eq("ovf8_flag_p2", ovf8, 0);
        cyc(0, 0, 0, 1, 42);
        check_eq("ovf8_p3", acc8, 20);
        check_eq("ovf8_flag", ovf8, 1);
        cyc(0, 0, 0, 0, 0);
        check_eq("ovf8_sticky", ovf8, 1);
        cyc(0, 1, 1, 0, 0);
        check_eq("ovf8_cleared", ovf8, 0);
        cyc(0, 0, 0, 1, 5);

        // Restart mid-run
        cyc(0, 1, 6, 0, 0);
        cyc(0, 0, 0, 1, 117);
        cyc(0, 0, 0, 1, 117);
        cyc(0, 1, 2, 1, 117);
        check_eq("restart_acc0", acc12, 0);
        cyc(0, 0, 0, 1, 42);
        cyc(0, 0, 0, 1, 50);
        check_eq("restart_acc", acc12, 92);
        check_eq("restart_done", done12, 1);

        // Back-to-back start while done
        cyc(0, 1, 5, 0, 0);
        check_eq("b2b_busy", busy12, 1);
        check_eq("b2b_acc", acc12, 0);
        cyc(0, 0, 0, 1, 33);
        // Reset mid-run
        cyc(1, 0, 0, 1, 60);
        check_eq("midrst_acc", acc12, 0);
        check_eq("midrst_busy", busy12, 0);
        check_eq("midrst_done", done12, 0);
        check_eq("midrst_ovf", ovf12, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(int'($urandom_range(0, 199) == 0),
                int'($urandom_range(0, 19) == 0),
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
